// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two cache-side request ports and the shared data-memory port
//   of dmem_arbiter.
//   slave  : arbiter side (requests and memory responses in, acks and memory request out)
//   master : environment side (caches + memory model)
//   p0_* : instruction cache port (enable/write/addr/data in, ack/data out)
//   p1_* : data cache port (same shape as p0)
//   mem_*: single 256-bit memory port (enable/write/addr/data out, ack/data in)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) ();
    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic              p0_ack_o;
    logic [DATA_W-1:0] p0_data_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic              p1_ack_o;
    logic [DATA_W-1:0] p1_data_o;

    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;

    modport slave (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p0_ack_o, p0_data_o,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_ack_o, p1_data_o,
        input  mem_data_i, mem_ack_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p0_ack_o, p0_data_o,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_ack_o, p1_data_o,
        output mem_data_i, mem_ack_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory line interface between the instruction cache
//   (port 0) and the data cache (port 1). The winning request is latched into
//   registered memory outputs, and completion is returned as a one-cycle
//   registered ack plus a read line held until that port's next read.
//   Ports:
//     clk_i : system clock
//     rst_i : asynchronous active-high reset
//     bus   : dmem_arbiter_if.slave (p0_*, p1_* cache ports, mem_* memory port)
//   Build option:
//     DMEM_ARB_RR_EN defined   -> round-robin arbitration on simultaneous requests
//     DMEM_ARB_RR_EN undefined -> fixed priority, port 1 wins ties
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no transaction; grant the next request if any enable is high
//   S_BUSY | memory request driven and held; waiting for mem_ack_i
//   S_DONE | owner's ack is high for this cycle; no grant allowed
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input logic          clk_i,
    input logic          rst_i,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_any_req;
    logic              w_grant;
    logic              w_grant_p1;
    logic              w_complete;

    logic              r_owner;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_p0_ack;
    logic              r_p1_ack;
    logic [DATA_W-1:0] r_p0_data;
    logic [DATA_W-1:0] r_p1_data;

    assign w_any_req = bus.p0_enable_i | bus.p1_enable_i;

`ifdef DMEM_ARB_RR_EN
    // Pointer names the preferred port; it only matters when both request.
    logic r_rr_ptr;

    always_comb begin
        w_grant_p1 = bus.p1_enable_i;
        if (bus.p0_enable_i && bus.p1_enable_i) begin
            w_grant_p1 = r_rr_ptr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant) begin
            r_rr_ptr <= ~w_grant_p1;
        end
    end
`else
    assign w_grant_p1 = bus.p1_enable_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Owner still sees its ack this cycle and may not have
                // dropped or replaced its request yet.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner      <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_data    <= '0;
            r_p1_data    <= '0;
        end else begin
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            if (w_grant) begin
                r_owner      <= w_grant_p1;
                r_mem_enable <= 1'b1;
                r_mem_write  <= w_grant_p1 ? bus.p1_write_i : bus.p0_write_i;
                r_mem_addr   <= w_grant_p1 ? bus.p1_addr_i  : bus.p0_addr_i;
                r_mem_data   <= w_grant_p1 ? bus.p1_data_i  : bus.p0_data_i;
            end
            if (w_complete) begin
                r_mem_enable <= 1'b0;
                r_mem_write  <= 1'b0;
                if (r_owner) begin
                    r_p1_ack <= 1'b1;
                end else begin
                    r_p0_ack <= 1'b1;
                end
                // Read lines stay held: the dcache writes its SRAM the
                // cycle after ack.
                if (!r_mem_write) begin
                    if (r_owner) begin
                        r_p1_data <= bus.mem_data_i;
                    end else begin
                        r_p0_data <= bus.mem_data_i;
                    end
                end
            end
        end
    end

    assign bus.mem_enable_o = r_mem_enable;
    assign bus.mem_write_o  = r_mem_write;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.p0_ack_o     = r_p0_ack;
    assign bus.p1_ack_o     = r_p1_ack;
    assign bus.p0_data_o    = r_p0_data;
    assign bus.p1_data_o    = r_p1_data;

endmodule
